// File: rtl/fadd_scheduler.sv
// Round-robin front end for a shared fixed-latency adder with an ordered response FIFO.
// Grants are credit-limited so every operation in flight always has a FIFO slot waiting for it.
module fadd_scheduler #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 3,
  parameter int DEPTH   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [N-1:0]              add_a,
  output logic [N-1:0]              add_b,
  output logic                      add_valid,
  input  logic [N-1:0]              add_sum,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [N-1:0]              rsp_sum,
  output logic [$clog2(NREQ)-1:0]   rsp_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  credits_q, credits_d;
  logic [N-1:0]   add_a_q, add_b_q;
  logic           add_valid_q;
  logic [IDW-1:0] add_id_q;
  logic [ADD_LAT-1:0] tag_v_q;
  logic [IDW-1:0] tag_id_q [ADD_LAT];

  logic [N-1:0]   mem_sum [DEPTH];
  logic [IDW-1:0] mem_id  [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            xfer;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover FIFO occupancy plus operations still in the adder.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (found && !reset && (credits_q < CW'(DEPTH))) grant[gnt_id] = 1'b1;
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign push      = tag_v_q[ADD_LAT-1];
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    rr_ptr_d = xfer ? gnt_id + IDW'(1) : rr_ptr_q;
    case ({xfer, pop})
      2'b10:   credits_d = credits_q + CW'(1);
      2'b01:   credits_d = credits_q - CW'(1);
      default: credits_d = credits_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      credits_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_valid_q <= 1'b0;
      add_id_q    <= '0;
      tag_v_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      credits_q   <= credits_d;
      add_valid_q <= xfer;
      if (xfer) begin
        add_a_q  <= req_a[gnt_id*N +: N];
        add_b_q  <= req_b[gnt_id*N +: N];
        add_id_q <= gnt_id;
      end
      for (int i = ADD_LAT - 1; i >= 1; i--) tag_v_q[i] <= tag_v_q[i-1];
      tag_v_q[0] <= add_valid_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Tag ids and FIFO storage need no reset; valids above qualify them.
  always_ff @(posedge clock) begin
    for (int i = ADD_LAT - 1; i >= 1; i--) tag_id_q[i] <= tag_id_q[i-1];
    tag_id_q[0] <= add_id_q;
    if (push && !reset) begin
      mem_sum[wr_ptr_q] <= add_sum;
      mem_id[wr_ptr_q]  <= tag_id_q[ADD_LAT-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) assert (count_q != CW'(DEPTH));
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_valid = add_valid_q;
  assign rsp_sum   = rsp_valid ? mem_sum[rd_ptr_q] : '0;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr_q]  : '0;

endmodule
